// File: rtl/fp_mult_result_buffer.sv
// Purpose: capture fp_mult z/status results into a DEPTH-entry FIFO, stall fp_mult by credit, keep sticky flags and a result count.
// Latency: a result is captured pipe_stages enabled edges after its issue is accepted; out_valid follows one cycle after capture.
// Backpressure: mult_enable drops when FIFO occupancy plus in-flight ops reaches DEPTH; out_ready has no combinational path to mult_enable.
module fp_mult_result_buffer #(
  parameter int sig_width   = 23,
  parameter int ex_width    = 8,
  parameter int pipe_stages = 0,
  parameter int DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         issue_valid,
  output logic                         mult_enable,
  input  logic [sig_width+ex_width:0]  mult_z,
  input  logic [7:0]                   mult_status,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [sig_width+ex_width:0]  out_z,
  output logic [7:0]                   out_status,
  input  logic                         flag_clr,
  output logic [5:0]                   acc_flags,
  output logic [15:0]                  result_cnt
);

  // Entry layout is {z, status}; status occupies the low byte.
  localparam int ZW = sig_width + ex_width + 1;
  localparam int EW = ZW + 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  // Sum of occupancy and in-flight ops needs headroom for up to 3 extra slots.
  localparam int SW = CW + 2;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [EW-1:0] r_mem [DEPTH];
  logic [EW-1:0] r_hold;
  logic [5:0]    r_acc;
  logic [15:0]   r_cnt;

  logic          w_cap_src;
  logic [SW-1:0] w_inflight;
  logic [SW-1:0] w_occupied;
  logic          w_wr;
  logic          w_rd;
  logic [EW-1:0] w_head;

  generate
    if (pipe_stages > 0) begin : g_pipe
      logic [pipe_stages-1:0] r_vline;

      // Valid tags advance in lockstep with the fp_mult pipeline, frozen while stalled.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_vline <= '0;
        end else if (mult_enable) begin
          r_vline[0] <= issue_valid;
          for (int i = 1; i < pipe_stages; i++) begin
            r_vline[i] <= r_vline[i-1];
          end
        end
      end

      // Number of real operations currently inside fp_mult.
      always_comb begin
        w_inflight = '0;
        for (int i = 0; i < pipe_stages; i++) begin
          w_inflight = w_inflight + SW'(r_vline[i]);
        end
      end

      assign w_cap_src = r_vline[pipe_stages-1];
    end else begin : g_nopipe
      // Combinational multiplier: the result is present in the issue cycle itself.
      assign w_cap_src  = issue_valid;
      assign w_inflight = '0;
    end
  endgenerate

  // Credit is computed from registered state only, so a push can never meet a full FIFO.
  assign w_occupied  = {{(SW-CW){1'b0}}, r_count} + w_inflight;
  assign mult_enable = (w_occupied < SW'(DEPTH));

  assign out_valid = (r_count != '0);
  assign w_wr      = mult_enable & w_cap_src;
  assign w_rd      = out_valid & out_ready;

  // When empty the outputs keep showing the entry most recently popped.
  assign w_head     = out_valid ? r_mem[r_rd_ptr] : r_hold;
  assign out_z      = w_head[EW-1:8];
  assign out_status = w_head[7:0];
  assign acc_flags  = r_acc;
  assign result_cnt = r_cnt;

  // Storage array: only entries between the pointers are ever observed, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {mult_z, mult_status};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged at any level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else begin
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Remember the departing head so an empty FIFO still presents its last value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hold <= '0;
    end else if (w_rd) begin
      r_hold <= r_mem[r_rd_ptr];
    end
  end

  // Sticky exception flags; a clear on a capture edge keeps only the new result's flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc <= '0;
    end else if (flag_clr) begin
      r_acc <= w_wr ? mult_status[5:0] : 6'd0;
    end else if (w_wr) begin
      r_acc <= r_acc | mult_status[5:0];
    end
  end

  // Saturating count of captured results, independent of flag_clr.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (w_wr && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fp_mult_result_buffer.sv
// Purpose: exercise three buffer instances (pipe_stages 3, 2, 0) with shared stimulus against a queue-based model.
// Latency: fp_mult is modelled as an enable-gated delay line carrying the result each issue will produce.
// Backpressure: expected mult_enable comes from the model's FIFO and in-flight queues, not from the DUT.
module tb_fp_mult_result_buffer;

  localparam int N     = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        issue_valid;
  logic        out_ready;
  logic        flag_clr;
  logic [31:0] in_z;
  logic [7:0]  in_st;

  logic        en [N];
  logic        ov [N];
  logic [31:0] oz [N];
  logic [7:0]  os [N];
  logic [5:0]  af [N];
  logic [15:0] rc [N];
  logic [31:0] mz [N];
  logic [7:0]  ms [N];

  logic [39:0] s3 [3];
  logic [39:0] s2 [2];

  int          ps [N];
  logic [39:0] fq [N][$];
  logic [71:0] iq [N][$];
  logic [31:0] ecnt [N];
  logic [39:0] last [N];
  logic [5:0]  acc [N];
  int          cnt [N];

  int errors = 0;
  int checks = 0;
  logic [15:0] r0, r2;

  always #5 clk = ~clk;

  // Stand-in fp_mult pipelines: shift the pending result only when enabled.
  always @(posedge clk) begin
    if (en[0]) begin
      s3[0] <= {in_z, in_st};
      s3[1] <= s3[0];
      s3[2] <= s3[1];
    end
    if (en[1]) begin
      s2[0] <= {in_z, in_st};
      s2[1] <= s2[0];
    end
  end

  assign mz[0] = s3[2][39:8];
  assign ms[0] = s3[2][7:0];
  assign mz[1] = s2[1][39:8];
  assign ms[1] = s2[1][7:0];
  assign mz[2] = in_z;
  assign ms[2] = in_st;

  fp_mult_result_buffer #(.sig_width(23), .ex_width(8), .pipe_stages(3), .DEPTH(DEPTH)) u_p3 (
    .clk(clk), .resetn(resetn), .issue_valid(issue_valid), .mult_enable(en[0]),
    .mult_z(mz[0]), .mult_status(ms[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_z(oz[0]), .out_status(os[0]), .flag_clr(flag_clr), .acc_flags(af[0]), .result_cnt(rc[0]));

  fp_mult_result_buffer #(.sig_width(23), .ex_width(8), .pipe_stages(2), .DEPTH(DEPTH)) u_p2 (
    .clk(clk), .resetn(resetn), .issue_valid(issue_valid), .mult_enable(en[1]),
    .mult_z(mz[1]), .mult_status(ms[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_z(oz[1]), .out_status(os[1]), .flag_clr(flag_clr), .acc_flags(af[1]), .result_cnt(rc[1]));

  fp_mult_result_buffer #(.sig_width(23), .ex_width(8), .pipe_stages(0), .DEPTH(DEPTH)) u_p0 (
    .clk(clk), .resetn(resetn), .issue_valid(issue_valid), .mult_enable(en[2]),
    .mult_z(mz[2]), .mult_status(ms[2]), .out_valid(ov[2]), .out_ready(out_ready),
    .out_z(oz[2]), .out_status(os[2]), .flag_clr(flag_clr), .acc_flags(af[2]), .result_cnt(rc[2]));

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_en(input int i);
    return (fq[i].size() + iq[i].size()) < DEPTH;
  endfunction

  task automatic check_all();
    logic [39:0] head;
    for (int i = 0; i < N; i++) begin
      head = (fq[i].size() > 0) ? fq[i][0] : last[i];
      chk($sformatf("enable[p%0d]", ps[i]), 40'(en[i]), 40'(exp_en(i)));
      chk($sformatf("out_valid[p%0d]", ps[i]), 40'(ov[i]), 40'(fq[i].size() > 0));
      chk($sformatf("head[p%0d]", ps[i]), {oz[i], os[i]}, head);
      chk($sformatf("acc_flags[p%0d]", ps[i]), 40'(af[i]), 40'(acc[i]));
      chk($sformatf("result_cnt[p%0d]", ps[i]), 40'(rc[i]), 40'(cnt[i]));
    end
  endtask

  // One clock edge of the reference behaviour, using pre-edge state and inputs.
  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      bit          e;
      bit          cap;
      bit          rd;
      logic [39:0] cp;
      e   = exp_en(i);
      rd  = (fq[i].size() > 0) && out_ready;
      cap = 1'b0;
      cp  = '0;
      if (e) begin
        ecnt[i] = ecnt[i] + 32'd1;
        if (ps[i] == 0) begin
          if (issue_valid) begin
            cap = 1'b1;
            cp  = {in_z, in_st};
          end
        end else begin
          if (iq[i].size() > 0 && iq[i][0][31:0] == ecnt[i]) begin
            cap = 1'b1;
            cp  = iq[i][0][71:32];
            void'(iq[i].pop_front());
          end
          if (issue_valid) iq[i].push_back({in_z, in_st, 32'(ecnt[i] + 32'(ps[i]))});
        end
      end
      if (rd) begin
        last[i] = fq[i][0];
        void'(fq[i].pop_front());
      end
      if (cap) fq[i].push_back(cp);
      if (flag_clr) acc[i] = cap ? cp[5:0] : 6'd0;
      else if (cap) acc[i] = acc[i] | cp[5:0];
      if (cap && cnt[i] < 65535) cnt[i] = cnt[i] + 1;
    end
  endtask

  task automatic step();
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic rand_payload();
    in_z  = $urandom;
    in_st = 8'($urandom_range(0, 63));
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    flag_clr    = 1'b0;
    rand_payload();
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    resetn = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_valid[p%0d]", ps[i]), 40'(ov[i]), 40'd0);
      chk($sformatf("rst_flags[p%0d]", ps[i]), 40'(af[i]), 40'd0);
      chk($sformatf("rst_cnt[p%0d]", ps[i]), 40'(rc[i]), 40'd0);
      chk($sformatf("rst_enable[p%0d]", ps[i]), 40'(en[i]), 40'd1);
      chk($sformatf("rst_z[p%0d]", ps[i]), {oz[i], os[i]}, 40'd0);
      fq[i].delete();
      iq[i].delete();
      ecnt[i] = '0;
      last[i] = '0;
      acc[i]  = '0;
      cnt[i]  = 0;
    end
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    ps          = '{3, 2, 0};
    resetn      = 1'b0;
    out_ready   = 1'b0;
    idle_inputs();
    @(negedge clk);
    do_reset();

    // 1.5 * 2.0 = 3.0: visible at cycle pipe_stages+1 for each instance.
    issue_valid = 1'b1;
    in_z        = 32'h40400000;
    in_st       = 8'h00;
    out_ready   = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) begin
      idle_inputs();
      chk("t1_valid_p3", 40'(ov[0]), 40'(k == 4));
      chk("t1_valid_p2", 40'(ov[1]), 40'(k == 3));
      chk("t1_valid_p0", 40'(ov[2]), 40'(k == 1));
      if (k == 4) begin
        chk("t1_z_p3", 40'(oz[0]), 40'h40400000);
        chk("t1_status_p3", 40'(os[0]), 40'h0);
        chk("t1_cnt_p3", 40'(rc[0]), 40'd1);
      end
      step();
    end

    // Backpressure: continuous issue with consumer stalled, then drain.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      rand_payload();
      issue_valid = 1'b1;
      step();
    end
    chk("t2_stall_p3", 40'(en[0]), 40'd0);
    chk("t2_stall_p2", 40'(en[1]), 40'd0);
    chk("t2_stall_p0", 40'(en[2]), 40'd0);
    chk("t2_landed_p3", 40'(rc[0]), 40'd1);
    chk("t2_landed_p2", 40'(rc[1]), 40'd2);
    chk("t2_landed_p0", 40'(rc[2]), 40'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      idle_inputs();
      step();
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t2_total[p%0d]", ps[i]), 40'(rc[i]), 40'd4);
      chk($sformatf("t2_empty[p%0d]", ps[i]), 40'(ov[i]), 40'd0);
    end

    // Sustained throughput from a full FIFO with continuous issue.
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rand_payload();
      issue_valid = 1'b1;
      step();
    end
    out_ready = 1'b1;
    for (int w = 0; w < 30; w++) begin
      rand_payload();
      issue_valid = 1'b1;
      if (w == 10) begin
        r0 = rc[1];
        r2 = rc[2];
      end
      if (w >= 10 && w <= 26) begin
        chk("t3_valid_p2", 40'(ov[1]), 40'd1);
        chk("t3_enable_p2", 40'(en[1]), 40'd1);
      end
      if (w == 26) begin
        chk("t3_rate_p2", 40'(16'(rc[1] - r0)), 40'd16);
        chk("t3_rate_p0", 40'(16'(rc[2] - r2)), 40'd16);
      end
      step();
    end

    // Sticky flags: inf*0 raises nan, which survives a clean 1.0*1.0.
    do_reset();
    out_ready   = 1'b1;
    issue_valid = 1'b1;
    in_z        = 32'h7FC00000;
    in_st       = 8'h04;
    step();
    in_z        = 32'h3F800000;
    in_st       = 8'h00;
    step();
    for (int k = 0; k < 6; k++) begin
      idle_inputs();
      step();
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t4_nan_sticky[p%0d]", ps[i]), 40'(af[i]), 40'h04);
    end
    // Inexact result whose capture edge coincides with flag_clr, per instance latency.
    issue_valid = 1'b1;
    in_z        = 32'h3F800001;
    in_st       = 8'h20;
    flag_clr    = 1'b1;
    step();
    idle_inputs();
    chk("t4_clr_wr_p0", 40'(af[2]), 40'h20);
    step();
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b1;
    chk("t4_clr_wr_p2", 40'(af[1]), 40'h20);
    step();
    flag_clr = 1'b0;
    chk("t4_clr_wr_p3", 40'(af[0]), 40'h20);
    step();

    // Reset with operations both in flight and queued.
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      rand_payload();
      issue_valid = 1'b1;
      step();
    end
    idle_inputs();
    step();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idle_inputs();
      for (int i = 0; i < N; i++) begin
        chk($sformatf("t5_no_stale[p%0d]", ps[i]), 40'(ov[i]), 40'd0);
      end
      step();
    end

    // Random traffic: sparse issues, toggling consumer, occasional clears.
    for (int k = 0; k < 400; k++) begin
      rand_payload();
      issue_valid = ($urandom_range(0, 1) == 1);
      out_ready   = ($urandom_range(0, 2) != 0) ? ~out_ready : out_ready;
      flag_clr    = ($urandom_range(0, 15) == 0);
      step();
    end
    idle_inputs();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
